sram_param_clr: RTL

//  Parametrised successor of the fixed 152b x 16 register-file SRAM model: configurable width/depth,
//  per-segment write mask, optional output register, and hardware clear-on-reset sweep.

---
 rtl/sram_param_clr_pkg.sv | 14 +
 rtl/sram_param_clr_if.sv | 26 ++
 rtl/sram_param_clr_ctrl.sv | 53 +++++
 rtl/sram_param_clr.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sram_param_clr_pkg.sv
// Shared types and helpers for the clear-on-reset SRAM model.
// State encoding for the sweep controller and segment width helper.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  function automatic int seg_w(int width, int num_seg);
    return width / num_seg;
  endfunction

endpackage

// File: rtl/sram_param_clr_if.sv
// Request/response bundle of the clear-on-reset SRAM.
// master drives requests, slave is the memory.
interface sram_param_clr_if #(
  parameter int WIDTH   = 152,
  parameter int ADDR_W  = 4,
  parameter int NUM_SEG = 8
);
  logic               CEN;
  logic               WEN;
  logic [ADDR_W-1:0]  A;
  logic [WIDTH-1:0]   D;
  logic [NUM_SEG-1:0] BWEN;
  logic [WIDTH-1:0]   Q;
  logic               VALID;
  logic               BUSY;

  modport master (
    output CEN, WEN, A, D, BWEN,
    input  Q, VALID, BUSY
  );

  modport slave (
    input  CEN, WEN, A, D, BWEN,
    output Q, VALID, BUSY
  );
endinterface

// File: rtl/sram_param_clr_ctrl.sv
// Clear sweep controller: zeroes every row after reset,
// holds BUSY until the last row has been written.
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    unique case (1'b1)
      (state_q == ST_CLEAR): begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          addr_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = addr_q;

endmodule

// File: rtl/sram_param_clr.sv
// Parametrised register-file SRAM with segment write mask,
// optional output register and hardware zeroing after reset.
module sram_param_clr
  import sram_pkg::*;
#(
  parameter int WIDTH   = 152,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_SEG = 8,
  parameter int OUT_REG = 0
) (
  input  logic CLK,
  input  logic RESET,
  sram_param_clr_if.slave bus
);

  localparam int SEG_W = seg_w(WIDTH, NUM_SEG);

  if (WIDTH % NUM_SEG != 0) begin : g_bad_seg
    $error("WIDTH must be a multiple of NUM_SEG");
  end
  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr
    $error("ADDR_W too narrow for DEPTH");
  end

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sram_clr_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ctrl (
    .clk       (CLK),
    .rst       (RESET),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  logic user_ok, rd_fire, wr_fire;

  assign user_ok = !RESET && !busy && !bus.CEN;
  assign rd_fire = user_ok && bus.WEN;
  assign wr_fire = user_ok && !bus.WEN && in_range(bus.A);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_row;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  wr_mask;

  // Sweep and user port never overlap: user traffic is gated by busy.
  always_comb begin
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    wr_mask = '0;
    if (clr_we && !RESET) begin
      wr_en   = 1'b1;
      wr_row  = clr_addr;
      wr_mask = '1;
    end else if (wr_fire) begin
      wr_en   = 1'b1;
      wr_row  = bus.A;
      wr_data = bus.D;
      for (int s = 0; s < NUM_SEG; s++) begin
        wr_mask[s*SEG_W +: SEG_W] = {SEG_W{~bus.BWEN[s]}};
      end
    end
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_row] <= (mem_q[wr_row] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [WIDTH-1:0]  rd_word;

  always_comb begin
    raddr_d = raddr_q;
    if (rd_fire) raddr_d = bus.A;
  end

  always_ff @(posedge CLK) begin
    if (RESET) raddr_q <= '0;
    else       raddr_q <= raddr_d;
  end

  always_comb begin
    rd_word = '0;
    if (in_range(raddr_q)) rd_word = mem_q[raddr_q];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic             pend_q, pend_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_comb begin
      pend_d  = rd_fire;
      valid_d = pend_q;
      out_d   = out_q;
      if (pend_q) out_d = rd_word;
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        pend_q  <= 1'b0;
        valid_q <= 1'b0;
        out_q   <= '0;
      end else begin
        pend_q  <= pend_d;
        valid_q <= valid_d;
        out_q   <= out_d;
      end
    end

    assign bus.Q     = out_q;
    assign bus.VALID = valid_q;
  end else begin : g_comb
    logic valid_q, valid_d;

    always_comb valid_d = rd_fire;

    always_ff @(posedge CLK) begin
      if (RESET) valid_q <= 1'b0;
      else       valid_q <= valid_d;
    end

    // Rows are stale until swept, so Q is masked while busy.
    assign bus.Q     = busy ? '0 : rd_word;
    assign bus.VALID = valid_q;
  end

  assign bus.BUSY = busy;

endmodule
